// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: it synchronizes and glitch-filters the PS/2 clock, then deframes
// 11-bit frames and decodes the F0 (release) and E0 (extended) prefixes into qualifier flags.
module ps2_scan_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       key_release,
    output logic       extended,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FiltLast = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WdMax    = WW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q, filt_prev_q;
    logic          fall, data_s;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          rel_q, rel_d, ext_q, ext_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          code_valid_q, code_valid_d;
    logic          key_release_q, key_release_d;
    logic          extended_q, extended_d;
    logic          frame_err_q, frame_err_d;

    assign data_s = data_sync_q[1];
    assign fall   = filt_prev_q & ~filt_clk_q;

    // Synchronizers and the stability filter idle high, matching an idle PS/2 bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_prev_q <= filt_clk_q;
            if (clk_sync_q[1] != filt_clk_q) begin
                if (filt_cnt_q == FiltLast) begin
                    filt_clk_q <= clk_sync_q[1];
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 1'b1;
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wd_q          <= '0;
            rel_q         <= 1'b0;
            ext_q         <= 1'b0;
            scan_code_q   <= '0;
            code_valid_q  <= 1'b0;
            key_release_q <= 1'b0;
            extended_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            wd_q          <= wd_d;
            rel_q         <= rel_d;
            ext_q         <= ext_d;
            scan_code_q   <= scan_code_d;
            code_valid_q  <= code_valid_d;
            key_release_q <= key_release_d;
            extended_q    <= extended_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        wd_d          = wd_q;
        rel_d         = rel_q;
        ext_d         = ext_q;
        scan_code_d   = scan_code_q;
        code_valid_d  = 1'b0;
        key_release_d = 1'b0;
        extended_d    = 1'b0;
        frame_err_d   = 1'b0;

        // Watchdog only runs inside a frame and saturates at its limit.
        if (state_q == StIdle || fall) begin
            wd_d = '0;
        end else if (wd_q != WdMax) begin
            wd_d = wd_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (fall && !data_s) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (data_s && (^{shift_q, parity_q})) begin
                        if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            scan_code_d   = shift_q;
                            code_valid_d  = 1'b1;
                            key_release_d = rel_q;
                            extended_d    = ext_q;
                            rel_d         = 1'b0;
                            ext_d         = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        rel_d       = 1'b0;
                        ext_d       = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && !fall && wd_q == WdMax) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            rel_d       = 1'b0;
            ext_d       = 1'b0;
        end
    end

    assign scan_code   = scan_code_q;
    assign code_valid  = code_valid_q;
    assign key_release = key_release_q;
    assign extended    = extended_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: frame-level reference model feeds an expectation queue that a
// negedge monitor drains whenever the receiver pulses code_valid or frame_err.
module tb_ps2_scan_rx;

    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 600;
    localparam int unsigned HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, key_release, extended, frame_err;

    ps2_scan_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .key_release (key_release),
        .extended    (extended),
        .frame_err   (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } exp_t;

    exp_t       expq[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       m_rel = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] m_code = 8'h00;

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (code_valid && frame_err) begin
                n_fail++;
                $display("FAIL both_pulses: code_valid=%0b frame_err=%0b required not both", code_valid, frame_err);
            end
            n_checks++;
            if (!code_valid && (key_release || extended)) begin
                n_fail++;
                $display("FAIL qual_idle: key_release=%0b extended=%0b required 0 0", key_release, extended);
            end
            if (code_valid || frame_err) begin
                exp_t act, e;
                act.err  = frame_err;
                act.code = scan_code;
                act.rel  = key_release;
                act.ext  = extended;
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got err=%0b code=%02h rel=%0b ext=%0b required none",
                             act.err, act.code, act.rel, act.ext);
                end else begin
                    e = expq.pop_front();
                    if (act != e) begin
                        n_fail++;
                        $display("FAIL pulse: got err=%0b code=%02h rel=%0b ext=%0b required err=%0b code=%02h rel=%0b ext=%0b",
                                 act.err, act.code, act.rel, act.ext, e.err, e.code, e.rel, e.ext);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        tick(HALF / 2);
        if (glitch) begin ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; end
        tick(HALF / 2);
        ps2_clk = 1'b0;
        tick(HALF / 2);
        if (glitch) begin ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0; end
        tick(HALF / 2);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit perr, input bit serr);
        logic par;
        par = ~(^b) ^ perr;
        return {~serr, par, b, 1'b0};
    endfunction

    task automatic check_drained(input string name);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pulses outstanding, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic model_err();
        exp_t e;
        e.err = 1'b1; e.code = m_code; e.rel = 1'b0; e.ext = 1'b0;
        expq.push_back(e);
        m_rel = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit perr, input bit serr, input bit glitch);
        logic [10:0] fr;
        exp_t        e;
        if (perr || serr) begin
            model_err();
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            e.err = 1'b0; e.code = b; e.rel = m_rel; e.ext = m_ext;
            expq.push_back(e);
            m_code = b;
            m_rel  = 1'b0;
            m_ext  = 1'b0;
        end
        fr = make_frame(b, perr, serr);
        for (int i = 0; i < 11; i++) ps2_bit(fr[i], glitch);
        ps2_data = 1'b1;
        tick(20);
        check_drained("frame_done");
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] fr;
        fr = make_frame(b, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic check_val(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %03h required %03h", name, act, req);
        end
    endtask

    initial begin
        tick(5);
        @(negedge clk);
        check_val("reset_state", {scan_code, code_valid, key_release, extended, frame_err}, 12'h000);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(10);

        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);

        send_frame(8'hE0, 0, 0, 0);
        tick(2 * TMO);
        check_drained("idle_no_timeout");
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);

        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'h1C, 0, 1, 0);
        @(negedge clk);
        check_val("code_hold_after_err", {4'h0, scan_code}, {4'h0, m_code});

        send_frame(8'hF0, 0, 0, 0);
        model_err();
        send_partial(8'h33, 5);
        tick(TMO + 50);
        check_drained("timeout");
        send_frame(8'h1C, 0, 0, 0);

        send_frame(8'h5A, 0, 0, 1);

        send_frame(8'hE0, 0, 0, 0);
        send_partial(8'h44, 5);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_rel = 1'b0; m_ext = 1'b0; m_code = 8'h00;
        @(negedge clk);
        check_val("mid_frame_reset", {scan_code, code_valid, key_release, extended, frame_err}, 12'h000);
        tick(TMO + 50);
        check_drained("no_err_after_reset");
        send_frame(8'h29, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int unsigned r;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
            send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0));
        end

        tick(TMO + 50);
        check_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter: FILTER_LEN, default 4; ps2_clk glitch filter length, in clk cycles of stability required.
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000; maximum clk cycles allowed between ps2_clk falling edges inside a frame (1 ms at 50 MHz).
REQ-003 Port: clk  input  1  system clock; all logic runs on the rising edge of clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ps2_clk  input  1  raw, asynchronous PS/2 clock from the keyboard.
REQ-006 Port: ps2_data  input  1  raw, asynchronous PS/2 data from the keyboard.
REQ-007 Port: scan_code  output  8  last complete non-prefix scan code; holds its value between codes.
REQ-008 Port: code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-009 Port: key_release  output  1  qualifies code_valid: code was preceded by the F0 prefix.
REQ-010 Port: extended  output  1  qualifies code_valid: code was preceded by the E0 prefix.
REQ-011 Port: frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-012 ps2_clk and ps2_data each SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The filtered clock SHALL change only after the synchronized ps2_clk holds a new level for FILTER_LEN consecutive cycles; the filter resets to 1 (idle high).
REQ-014 A falling edge (fall) SHALL be a 1-to-0 transition of the filtered clock; fall is high for exactly 1 cycle.
REQ-015 Synchronized ps2_data SHALL be sampled only in fall cycles.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: on fall with data=0 go to DATA and clear the bit counter; on fall with data=1 stay in IDLE with no error.
REQ-018 DATA: on each fall, shift data in LSB-first; after the 8th bit go to PARITY.
REQ-019 PARITY: on fall, store the parity bit and go to STOP; odd parity is required (the 8 data bits plus parity contain an odd number of ones).
REQ-020 STOP: on fall, go to IDLE; if stop=1 and parity is good, the frame is accepted, otherwise frame_err pulses.
REQ-021 Accepted byte 0xF0: set the release flag; no code_valid.
REQ-022 Accepted byte 0xE0: set the extended flag; no code_valid.
REQ-023 Any other accepted byte: scan_code<=byte, code_valid=1, key_release=release flag, extended=extended flag, all in the same cycle; then both flags clear.
REQ-024 Latency: code_valid and frame_err SHALL assert in the cycle after the fall that samples the stop bit.
REQ-025 key_release and extended SHALL be 0 whenever code_valid is 0.
REQ-026 Timeout: a watchdog counter clears on every fall and counts while the state is not IDLE; on reaching TIMEOUT_CYCLES the FSM goes to IDLE and frame_err pulses.
REQ-027 Any frame_err SHALL also clear the release and extended flags.
REQ-028 Counter width SHALL be clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
REQ-029 code_valid and frame_err SHALL never be high in the same cycle.
REQ-030 Prefix sequences: E0 followed by F0 sets both flags; a repeated F0 keeps the release flag set; flags persist across idle time with no timeout while in IDLE.

Reset
REQ-031 In any cycle with reset=1, the FSM SHALL go to IDLE.
REQ-032 Reset SHALL clear the bit counter, shift register, watchdog and both flags.
REQ-033 Reset SHALL set scan_code=0x00 and code_valid=key_release=extended=frame_err=0.
REQ-034 Reset SHALL return the synchronizers and the filter to 1.
REQ-035 Reset mid-frame SHALL discard the partial frame with no frame_err; the next start bit begins a fresh frame.

Verification
REQ-036 Make frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at 10 kHz -> one code_valid pulse, scan_code=0x1C, key_release=0, extended=0.
REQ-037 Frames F0, 1C -> no pulse after F0; after 1C, code_valid=1 with key_release=1; then frame 1C alone -> key_release=0.
REQ-038 Frames E0, F0, 75 -> a single code_valid with scan_code=0x75, extended=1, key_release=1.
REQ-039 Frame 0x1C with parity=1, then a separate frame 0x1C with stop=0 -> one frame_err pulse each, no code_valid, scan_code unchanged.
REQ-040 Five bits then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, return to IDLE; a following good 0x1C frame decodes correctly.
REQ-041 1-cycle ps2_clk glitches (with FILTER_LEN=4) -> no bit sampled; reset asserted after bit 4 -> no frame_err, then the next frame 0x29 gives scan_code=0x29.
